// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the video/CPU bus: the access FSM state encoding and
// the master index constants. The address decoder and future bus masters
// import this package so they agree on both encodings.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    // Access sequence: every access runs IDLE -> ISSUE -> DONE -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } bus_state_t;

    // Master indices: master 0 is the CPU/control port, master 1 the video updater.
    localparam logic MASTER_0 = 1'b0;
    localparam logic MASTER_1 = 1'b1;

    // The index of the master that is not 'm'.
    function automatic logic other_master(input logic m);
        return ~m;
    endfunction

endpackage

// File: rtl/bus_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection for the two-master bus.
//   vsync        : vertical-blank window; decides who wins a plain tie
//   m0_req       : master 0 request
//   m1_req       : master 1 request
//   last_winner  : master that received the most recent grant
//   burst_full   : last_winner has held the bus for MAX_BURST grants in a row
//   grant_valid  : at least one master is requesting
//   winner       : selected master (meaningful only when grant_valid is high)
// -----------------------------------------------------------------------------
module arb_pick
    import bus_arbiter_pkg::*;
(
    input  logic vsync,
    input  logic m0_req,
    input  logic m1_req,
    input  logic last_winner,
    input  logic burst_full,
    output logic grant_valid,
    output logic winner
);

    // NOTE: every output of an always_comb block gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant_valid = m0_req | m1_req;
        winner      = MASTER_0;
        if (m0_req && !m1_req) begin
            winner = MASTER_0;
        end else if (m1_req && !m0_req) begin
            winner = MASTER_1;
        end else if (m0_req && m1_req) begin
            // A master that has held the bus for a full burst yields to the
            // waiting one, whatever the blanking priority says.
            if (burst_full) begin
                winner = other_master(last_winner);
            end else begin
                winner = vsync ? MASTER_1 : MASTER_0;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master arbiter for the shared video/CPU bus. Each access takes three
// cycles (IDLE -> ISSUE -> DONE); the winner's address, write data and
// direction are registered onto the shared bus in ISSUE, read data is
// captured at the end of ISSUE and the winner gets a one-cycle ack in DONE.
// During vertical blank the video updater wins ties, otherwise the CPU does;
// a burst limit of MAX_BURST consecutive grants keeps either side from
// starving the other.
//   clk                 : system clock, rising edge
//   reset               : asynchronous reset, active low
//   vsync               : vertical-blank window
//   m0_* / m1_*         : per-master req, addr, wdata, rw (1 = write),
//                         ack (single-cycle pulse) and rdata (held until
//                         the next ack)
//   addr / data / rw    : shared bus address, write data, direction
//   din                 : shared bus read data from the decoder mux
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    input  logic        m0_rw,
    output logic        m0_ack,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    input  logic        m1_rw,
    output logic        m1_ack,
    output logic [7:0]  m1_rdata,
    output logic [15:0] addr,
    output logic [7:0]  data,
    output logic        rw,
    input  logic [7:0]  din
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    bus_state_t       state;
    bus_state_t       next_state;
    logic             load_bus;     // IDLE grant: register the winner's request
    logic             finish;       // ISSUE->DONE: capture din, raise ack
    logic             last_winner;  // also the owner of the access in flight
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_full;
    logic             grant_valid;
    logic             winner;

    assign burst_full = (burst_cnt == BURST_LIMIT);

    arb_pick u_arb_pick (
        .vsync       (vsync),
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .last_winner (last_winner),
        .burst_full  (burst_full),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requests are looked at only in IDLE; DONE is a fixed turnaround cycle.
    always_comb begin
        next_state = state;
        load_bus   = 1'b0;
        finish     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    load_bus   = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                finish     = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Registered bus, acks, read data and burst tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr        <= 16'h0000;
            data        <= 8'h00;
            rw          <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= 8'h00;
            m1_rdata    <= 8'h00;
            burst_cnt   <= '0;
            last_winner <= MASTER_0;
        end else begin
            // Acks are single-cycle: high only in the cycle after 'finish'.
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;

            if (load_bus) begin
                if (winner == MASTER_1) begin
                    addr <= m1_addr;
                    data <= m1_wdata;
                    rw   <= m1_rw;
                end else begin
                    addr <= m0_addr;
                    data <= m0_wdata;
                    rw   <= m0_rw;
                end
                last_winner <= winner;
                if (winner != last_winner) begin
                    burst_cnt <= CNT_W'(1);
                end else if (!burst_full) begin
                    burst_cnt <= burst_cnt + CNT_W'(1);
                end
            end

            if (finish) begin
                // The bus is parked at zero through DONE.
                addr <= 16'h0000;
                data <= 8'h00;
                rw   <= 1'b0;
                if (last_winner == MASTER_1) begin
                    m1_ack   <= 1'b1;
                    m1_rdata <= din;
                end else begin
                    m0_ack   <= 1'b1;
                    m0_rdata <= din;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter. A transaction-level reference model
// keeps the list of past grants and the last read data per master, and picks
// each winner straight from the arbitration rules. Directed steps cover reset,
// single read, both tie cases, fairness, reset mid-access and back-to-back
// traffic, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vsync = 1'b0;
    logic        m0_req = 1'b0;
    logic [15:0] m0_addr = 16'h0000;
    logic [7:0]  m0_wdata = 8'h00;
    logic        m0_rw = 1'b0;
    logic        m0_ack;
    logic [7:0]  m0_rdata;
    logic        m1_req = 1'b0;
    logic [15:0] m1_addr = 16'h0000;
    logic [7:0]  m1_wdata = 8'h00;
    logic        m1_rw = 1'b0;
    logic        m1_ack;
    logic [7:0]  m1_rdata;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic [7:0]  din = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int         hist[$];        // winners of all grants since reset, oldest first
    logic [7:0] exp_rdata[2];
    int         last_w;

    bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .reset    (reset),
        .vsync    (vsync),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_rw    (m0_rw),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_rw    (m1_rw),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .addr     (addr),
        .data     (data),
        .rw       (rw),
        .din      (din)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arbitration rules: a lone requester wins; on a tie, a master that took
    // the last MAX_BURST grants yields, otherwise vsync picks (1 -> master 1).
    function automatic int model_pick(input logic r0, input logic r1, input logic v);
        int owner;
        bit streak;
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (hist.size() >= MAX_BURST) begin
            owner  = hist[hist.size() - 1];
            streak = 1'b1;
            for (int k = 1; k < MAX_BURST; k++) begin
                if (hist[hist.size() - 1 - k] != owner) streak = 1'b0;
            end
            if (streak) return 1 - owner;
        end
        return v ? 1 : 0;
    endfunction

    function automatic logic [15:0] addr_of(input int m);
        return (m == 1) ? m1_addr : m0_addr;
    endfunction

    function automatic logic [7:0] wdata_of(input int m);
        return (m == 1) ? m1_wdata : m0_wdata;
    endfunction

    function automatic logic rw_of(input int m);
        return (m == 1) ? m1_rw : m0_rw;
    endfunction

    function automatic logic ack_of(input int m);
        return (m == 1) ? m1_ack : m0_ack;
    endfunction

    function automatic logic [7:0] rdata_of(input int m);
        return (m == 1) ? m1_rdata : m0_rdata;
    endfunction

    task automatic set_req(input int m, input logic r);
        if (m == 1) m1_req = r;
        else        m0_req = r;
    endtask

    task automatic new_req(input int m, input logic [15:0] a, input logic [7:0] wd, input logic w);
        if (m == 1) begin
            m1_req = 1'b1; m1_addr = a; m1_wdata = wd; m1_rw = w;
        end else begin
            m0_req = 1'b1; m0_addr = a; m0_wdata = wd; m0_rw = w;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " addr"}, addr, 16'h0000);
        check({tag, " data"}, 16'(data), 16'h0000);
        check({tag, " rw"}, 16'(rw), 16'h0000);
        check({tag, " m0_ack"}, 16'(m0_ack), 16'h0000);
        check({tag, " m1_ack"}, 16'(m1_ack), 16'h0000);
        check({tag, " m0_rdata"}, 16'(m0_rdata), 16'h0000);
        check({tag, " m1_rdata"}, 16'(m1_rdata), 16'h0000);
    endtask

    task automatic apply_reset();
        reset  = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        vsync  = 1'b0;
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        check_reset_outputs("reset held");
        reset = 1'b1;
        hist.delete();
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
    endtask

    // Runs one IDLE decision with the inputs as currently driven. With a
    // grant it follows the access through ISSUE and DONE back to IDLE.
    // 'wobble' toggles vsync and may drop the winner's req mid-access,
    // neither of which may disturb the access in flight.
    task automatic access(input logic [7:0] din_val, input bit wobble);
        int w;
        int o;
        w = model_pick(m0_req, m1_req, vsync);
        last_w = w;
        tick();
        if (w < 0) begin
            check("idle addr", addr, 16'h0000);
            check("idle rw", 16'(rw), 16'h0000);
            check("idle m0_ack", 16'(m0_ack), 16'h0000);
            check("idle m1_ack", 16'(m1_ack), 16'h0000);
            return;
        end
        o = 1 - w;
        check("issue addr", addr, addr_of(w));
        check("issue data", 16'(data), 16'(wdata_of(w)));
        check("issue rw", 16'(rw), 16'(rw_of(w)));
        check("issue m0_ack", 16'(m0_ack), 16'h0000);
        check("issue m1_ack", 16'(m1_ack), 16'h0000);
        hist.push_back(w);
        din = din_val;
        if (wobble) begin
            vsync = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) set_req(w, 1'b0);
        end
        tick();
        check("done winner ack", 16'(ack_of(w)), 16'h0001);
        check("done other ack", 16'(ack_of(o)), 16'h0000);
        check("done winner rdata", 16'(rdata_of(w)), 16'(din_val));
        check("done other rdata", 16'(rdata_of(o)), 16'(exp_rdata[o]));
        check("done addr", addr, 16'h0000);
        check("done data", 16'(data), 16'h0000);
        check("done rw", 16'(rw), 16'h0000);
        exp_rdata[w] = din_val;
        din = 8'($urandom);
        tick();
        check("after m0_ack", 16'(m0_ack), 16'h0000);
        check("after m1_ack", 16'(m1_ack), 16'h0000);
        check("after rw", 16'(rw), 16'h0000);
        check("after rdata hold", 16'(rdata_of(w)), 16'(exp_rdata[w]));
    endtask

    initial begin
        last_w = -1;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;

        // Reset state.
        apply_reset();

        // Single read from master 0 outside blank.
        vsync = 1'b0;
        new_req(0, 16'h0000, 8'h33, 1'b0);
        access(8'h5A, 1'b0);
        m0_req = 1'b0;
        check("single read rdata", 16'(m0_rdata), 16'h005A);

        // Tie outside blank: master 0 first, master 1 in the following IDLE.
        vsync = 1'b0;
        new_req(0, 16'h1234, 8'hA1, 1'b1);
        new_req(1, 16'h8001, 8'hB2, 1'b0);
        access(8'h11, 1'b0);
        m0_req = 1'b0;
        access(8'h22, 1'b0);
        m1_req = 1'b0;

        // Tie during blank: master 1 writes 8'h07 to 16'hF203.
        vsync = 1'b1;
        new_req(0, 16'h0040, 8'h99, 1'b0);
        new_req(1, 16'hF203, 8'h07, 1'b1);
        access(8'h3C, 1'b0);
        m1_req = 1'b0;
        access(8'h4D, 1'b0);
        m0_req = 1'b0;

        // Fairness: master 1 requests continuously in blank; after four
        // master 1 grants the fifth goes to master 0.
        apply_reset();
        vsync = 1'b1;
        new_req(0, 16'h0100, 8'h01, 1'b0);
        new_req(1, 16'h2000, 8'h02, 1'b1);
        for (int i = 0; i < 6; i++) begin
            access(8'(8'h60 + i), 1'b0);
            if (last_w == 0) m0_req = 1'b0;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;

        // Reset asserted during ISSUE abandons the access.
        new_req(0, 16'hABCD, 8'hEE, 1'b1);
        tick();
        check("pre-reset issue rw", 16'(rw), 16'h0001);
        reset  = 1'b0;
        m0_req = 1'b0;
        #1;
        check_reset_outputs("mid-access reset");
        tick();
        check_reset_outputs("mid-access reset held");
        reset = 1'b1;
        hist.delete();
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        tick();
        check_reset_outputs("after release idle");
        new_req(1, 16'h0F0F, 8'h5C, 1'b0);
        access(8'h77, 1'b0);
        m1_req = 1'b0;

        // Back-to-back from master 0: an ack every third cycle.
        vsync = 1'b0;
        new_req(0, 16'h0200, 8'h10, 1'b1);
        for (int i = 0; i < 4; i++) access(8'(8'h80 + i), 1'b0);
        m0_req = 1'b0;

        // Randomized traffic; requests stay stable until their ack.
        for (int i = 0; i < 300; i++) begin
            if (!m0_req && $urandom_range(0, 2) != 0)
                new_req(0, 16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            if (!m1_req && $urandom_range(0, 2) != 0)
                new_req(1, 16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            vsync = ($urandom_range(0, 3) != 0);
            access(8'($urandom), 1'b1);
            if (last_w >= 0 && $urandom_range(0, 1) == 1) set_req(last_w, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the consecutive grants one master may hold while the other waits.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 vsync  input  1  vertical-blank window, synchronous to clk.
REQ-005 m0_req / m1_req  input  1 each  access request from master 0 (CPU/control) and master 1 (video updater).
REQ-006 m0_addr / m1_addr  input  16 each  access address.
REQ-007 m0_wdata / m1_wdata  input  8 each  write data.
REQ-008 m0_rw / m1_rw  input  1 each  1 = write, 0 = read.
REQ-009 m0_ack / m1_ack  output  1 each  single-cycle completion pulse.
REQ-010 m0_rdata / m1_rdata  output  8 each  read data, valid while the matching ack is high.
REQ-011 addr  output  16  shared bus address to the address decoder.
REQ-012 data  output  8  shared bus write data.
REQ-013 rw  output  1  shared bus direction, 1 = write.
REQ-014 din  input  8  shared bus read data from the decoder mux.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE, DONE; every access SHALL take exactly IDLE->ISSUE->DONE->IDLE (3 cycles).
REQ-016 In IDLE with at least one req high, the arbiter SHALL choose a winner, register its addr/wdata/rw onto addr/data/rw and enter ISSUE; with no req it SHALL stay in IDLE.
REQ-017 Priority: vsync high -> master 1 wins ties; vsync low -> master 0 wins ties.
REQ-018 Fairness override: if the last MAX_BURST grants all went to one master and the other master requests, the other master SHALL win regardless of vsync.
REQ-019 The burst counter SHALL reset to 1 when the winner changes, increment on a repeat winner and saturate at MAX_BURST.
REQ-020 In ISSUE the bus outputs SHALL hold; on the ISSUE->DONE edge the arbiter SHALL capture din into the winner's rdata, pulse the winner's ack for the DONE cycle and drive rw to 0.
REQ-021 In DONE the arbiter SHALL drive addr to 16'h0000, data to 8'h00 and rw to 0, and return to IDLE unconditionally (turnaround; req is not sampled in DONE).
REQ-022 Writes SHALL also produce ack; rdata for a write SHALL equal din captured that cycle (don't-care to the master).
REQ-023 A master SHALL hold addr/wdata/rw stable from req assertion until its ack; dropping req before ack SHALL NOT abort the access.
REQ-024 A master's rdata SHALL hold its last captured value until its next ack.
REQ-025 The ack outputs SHALL be one-hot or zero; rw SHALL be high only in ISSUE.
REQ-026 A change of vsync while in ISSUE or DONE SHALL NOT affect the access in flight; it SHALL affect only the next IDLE decision.

Reset
REQ-027 While reset is low: state = IDLE, addr = 16'h0000, data = 8'h00, rw = 0, both acks 0, both rdata 8'h00, burst counter 0, last winner = master 0.
REQ-028 Reset asserted mid-access SHALL abandon the access with no ack; after release the first access SHALL begin from IDLE.

Structure
REQ-029 The FSM state encodings (IDLE/ISSUE/DONE) and the master index constants SHALL live in a shared bus package reused by the decoder and later masters.
REQ-030 Winner selection (priority plus fairness) SHALL be a combinational sub-module named arb_pick; the FSM, registered bus and burst counter SHALL stay in bus_arbiter.

Verification
REQ-031 Single read: vsync=0, m0 read 16'h0000, din=8'h5A -> addr=16'h0000 and rw=0 in ISSUE; m0_ack on cycle 3; m0_rdata=8'h5A.
REQ-032 Tie outside blank: vsync=0, m0 and m1 request together -> m0 is granted first; m1 is granted in the next IDLE (6 cycles to the m1 ack).
REQ-033 Tie in blank: vsync=1, m0 and m1 request together, m1 writes 8'h07 to 16'hF203 -> m1 wins; addr=16'hF203, data=8'h07, rw=1 for one cycle.
REQ-034 Fairness: vsync=1, m1 requests continuously, m0 requests -> after 4 m1 acks, the 5th grant goes to m0.
REQ-035 Reset mid-access: reset low during ISSUE -> no ack; all outputs at their reset values; the bus is idle on release.
REQ-036 Back-to-back from one master: m0 requests continuously -> an ack every 3 cycles; rw is never high in DONE or IDLE.
